axi_lite_ic_arbiter: RTL and testbench
======================================

# axi_lite_ic_arbiter

Round-robin transaction arbiter for the AXI4-Lite interconnect. It shares one slave port between NUM_M master ports by granting exactly one whole transaction (AW/W/B or AR/R) at a time. It watches per-master request lines and slave-side completion strobes, and drives a one-hot grant that the interconnect muxes use to steer channels. An optional watchdog reclaims the slave port when a transaction never completes.

## Interface
Parameters:
- NUM_M, 2, number of master ports; legal range 2..8
- TIMEOUT, 256, watchdog limit in cycles of grant without completion; legal range 2..65535; used only with the watchdog compiled in

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset_n  in  1  reset; synchronous, active-low
- aw_req  in  NUM_M  bit i = master i awvalid
- ar_req  in  NUM_M  bit i = master i arvalid
- wr_done  in  1  slave-side bvalid & bready (write transaction complete)
- rd_done  in  1  slave-side rvalid & rready (read transaction complete)
- grant  out  NUM_M  one-hot owner of the slave port; all zero when idle
- grant_id  out  max(1,$clog2(NUM_M))  binary index of the owner; 0 when idle
- grant_write  out  1  1 = granted transaction is a write, 0 = read; 0 when idle
- busy  out  1  1 while a grant is held
- timeout  out  1  one-cycle pulse when the watchdog reclaims a grant

## Operation
- FSM states: IDLE, WR, RD. All outputs are registered.
- Reset, applied while areset_n is low at a rising edge, from any state: state=IDLE, grant=0, grant_id=0, grant_write=0, busy=0, timeout=0, rr_ptr=NUM_M-1 (master 0 wins first), dir_pref=write, watchdog count=0.
- Master i is pending when aw_req[i] | ar_req[i].
- IDLE with any master pending:
  - Select the first pending master searching rr_ptr+1, rr_ptr+2, … modulo NUM_M.
  - Master has only aw_req: grant a write (go to WR).
  - Master has only ar_req: grant a read (go to RD).
  - Master has both: use dir_pref, then toggle dir_pref.
- IDLE with nothing pending: stay in IDLE; outputs remain zero.
- WR: hold the grant until wr_done=1. rd_done is ignored.
- RD: hold the grant until rd_done=1. wr_done is ignored.
- On completion:
  - Go to IDLE.
  - Set rr_ptr to the granted index.
  - Clear grant, grant_id, grant_write and busy on the same edge.
- Requests dropping while a grant is held do not release the grant. Only a completion, the watchdog or reset releases it.
- Completion strobes arriving in IDLE are ignored.
- At most one grant is active at any time; no preemption.

## Timing
- A request sampled at edge k makes grant/busy valid after edge k, so the grant is visible in cycle k+1.
- A completion sampled at edge m makes grant=0 in cycle m+1.
- The earliest next grant is after edge m+1, giving a one-cycle idle bubble between transactions.
- Worst-case wait for a continuously requesting master is (NUM_M-1) transactions.
- A master requesting both read and write alternates directions across its own grants.

## Configuration
- AXI_LITE_ARB_TIMEOUT_EN defined:
  - A 16-bit counter resets on each grant and increments every cycle in WR/RD.
  - If the counter reaches TIMEOUT-1 with no matching completion, at the next edge the FSM goes to IDLE, releases the grant, sets rr_ptr to the owner, and pulses timeout=1 for one cycle.
  - If the matching completion arrives in the expiry cycle, the completion wins and no timeout pulse is produced.
- AXI_LITE_ARB_TIMEOUT_EN undefined: no counter is built, timeout is tied to 0, and a grant is held indefinitely until completion.

## Test plan
- Reset: hold areset_n=0 for 2 edges with aw_req=2'b11 -> grant=0, grant_id=0, grant_write=0, busy=0, timeout=0. Release reset -> grant=2'b01 one cycle later.
- Single write: NUM_M=2, aw_req=2'b10 from cycle 0 -> cycle 1: grant=2'b10, grant_id=1, grant_write=1, busy=1. wr_done pulse in cycle 5 -> grant=0 in cycle 6.
- Fairness: aw_req=2'b11 held, wr_done pulsed 3 cycles after each grant -> grant sequence 01,10,01,10 with exactly one idle cycle between grants.
- Direction alternation: master 0 with aw_req=1 and ar_req=1 held -> first grant write, second grant read, third write. In WR a stray rd_done pulse leaves the grant unchanged.
- Reset mid-grant: grant active in RD, areset_n=0 for one edge -> all outputs 0 next cycle, and the next arbitration starts from master 0.
- Watchdog: with the macro defined, TIMEOUT=8, ar_req=2'b01 granted in cycle 1 and no rd_done -> grant drops and timeout=1 for one cycle at cycle 9, after which master 1 (if requesting) wins. With the macro undefined, the grant is still held at cycle 100.

Source files
------------

// File: rtl/axi_lite_ic_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : axi_lite_ic_arbiter
// Description : Round-robin whole-transaction arbiter sharing one AXI4-Lite
//               slave port between NUM_M masters. The optional watchdog is
//               compiled in with the macro AXI_LITE_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_ic_arbiter #(
    parameter  int NUM_M   = 2,
    parameter  int TIMEOUT = 256,
    localparam int c_IDW   = (NUM_M > 2) ? $clog2(NUM_M) : 1
) (
    input  logic             aclk,
    input  logic             areset_n,
    input  logic [NUM_M-1:0] aw_req,
    input  logic [NUM_M-1:0] ar_req,
    input  logic             wr_done,
    input  logic             rd_done,
    output logic [NUM_M-1:0] grant,
    output logic [c_IDW-1:0] grant_id,
    output logic             grant_write,
    output logic             busy,
    output logic             timeout
);

    if ((NUM_M < 2) || (NUM_M > 8) || (TIMEOUT < 2) || (TIMEOUT > 65535)) begin : g_param_check
        $error("axi_lite_ic_arbiter: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_M-1:0]   r_grant;
    logic [c_IDW-1:0]   r_grant_id;
    logic               r_grant_write;
    logic               r_busy;
    logic [c_IDW-1:0]   r_rr_ptr;
    logic               r_dir_pref;     // 1 = next dual-request grant is a write

    state_t             w_state_nxt;
    logic [NUM_M-1:0]   w_grant_nxt;
    logic [c_IDW-1:0]   w_grant_id_nxt;
    logic               w_grant_write_nxt;
    logic               w_busy_nxt;
    logic [c_IDW-1:0]   w_rr_ptr_nxt;
    logic               w_dir_pref_nxt;

    logic [NUM_M-1:0]   w_pend;
    logic               w_found;
    logic [c_IDW-1:0]   w_sel;
    logic [c_IDW:0]     w_sum;
    logic [c_IDW-1:0]   w_cand;
    logic               w_both;
    logic               w_wr;
    logic               w_done;
    logic               w_release;

`ifdef AXI_LITE_ARB_TIMEOUT_EN
    logic [15:0]        r_wdog;
    logic               r_timeout;
    logic [15:0]        w_wdog_nxt;
    logic               w_timeout_nxt;
`endif

    assign w_pend = aw_req | ar_req;

    // Scan from the highest offset down so the last hit is the first pending
    // master after rr_ptr; avoids a loop exit in hardware.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = NUM_M; k >= 1; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (c_IDW+1)'(k);
            if (w_sum >= (c_IDW+1)'(NUM_M)) begin
                w_sum = w_sum - (c_IDW+1)'(NUM_M);
            end
            w_cand = w_sum[c_IDW-1:0];
            if (w_pend[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_grant_id_nxt    = r_grant_id;
        w_grant_write_nxt = r_grant_write;
        w_busy_nxt        = r_busy;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_dir_pref_nxt    = r_dir_pref;
        w_both            = 1'b0;
        w_wr              = 1'b0;
        w_done            = 1'b0;
        w_release         = 1'b0;
`ifdef AXI_LITE_ARB_TIMEOUT_EN
        w_wdog_nxt        = r_wdog;
        w_timeout_nxt     = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_both = aw_req[w_sel] & ar_req[w_sel];
                    w_wr   = aw_req[w_sel] & (~ar_req[w_sel] | r_dir_pref);
                    if (w_both) begin
                        w_dir_pref_nxt = ~r_dir_pref;
                    end
                    w_state_nxt         = w_wr ? S_WR : S_RD;
                    w_grant_nxt         = '0;
                    w_grant_nxt[w_sel]  = 1'b1;
                    w_grant_id_nxt      = w_sel;
                    w_grant_write_nxt   = w_wr;
                    w_busy_nxt          = 1'b1;
`ifdef AXI_LITE_ARB_TIMEOUT_EN
                    w_wdog_nxt          = '0;
`endif
                end
            end
            S_WR, S_RD: begin
                // Only the completion matching the granted direction counts.
                w_done = (r_state == S_WR) ? wr_done : rd_done;
                if (w_done) begin
                    w_release = 1'b1;
                end
`ifdef AXI_LITE_ARB_TIMEOUT_EN
                else if (r_wdog == 16'(TIMEOUT - 1)) begin
                    w_release     = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wdog_nxt = r_wdog + 16'd1;
                end
`endif
            end
            default: begin
                w_release = 1'b1;
            end
        endcase

        if (w_release) begin
            w_state_nxt       = S_IDLE;
            w_grant_nxt       = '0;
            w_grant_id_nxt    = '0;
            w_grant_write_nxt = 1'b0;
            w_busy_nxt        = 1'b0;
            w_rr_ptr_nxt      = r_grant_id;
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_write <= 1'b0;
            r_busy        <= 1'b0;
            r_rr_ptr      <= c_IDW'(NUM_M - 1);
            r_dir_pref    <= 1'b1;
`ifdef AXI_LITE_ARB_TIMEOUT_EN
            r_wdog        <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_grant_write <= w_grant_write_nxt;
            r_busy        <= w_busy_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_dir_pref    <= w_dir_pref_nxt;
`ifdef AXI_LITE_ARB_TIMEOUT_EN
            r_wdog        <= w_wdog_nxt;
            r_timeout     <= w_timeout_nxt;
`endif
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_write = r_grant_write;
    assign busy        = r_busy;
`ifdef AXI_LITE_ARB_TIMEOUT_EN
    assign timeout     = r_timeout;
`else
    assign timeout     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_ic_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_ic_arbiter
// Description : Randomised scoreboard bench for axi_lite_ic_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_ic_arbiter;

    localparam int N   = 2;
    localparam int TO  = 8;
    localparam int IDW = 1;
`ifdef AXI_LITE_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0]   grant;
        logic [IDW-1:0] id;
        logic           wr;
        logic           busy;
        logic           to;
    } exp_t;

    logic           clk = 1'b0;
    logic           areset_n;
    logic [N-1:0]   aw_req;
    logic [N-1:0]   ar_req;
    logic           wr_done;
    logic           rd_done;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_write;
    logic           busy;
    logic           timeout;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: owner index (-1 = idle) and cycles the grant has been visible.
    int   m_owner   = -1;
    bit   m_write   = 1'b0;
    int   m_rr      = N - 1;
    bit   m_pref_wr = 1'b1;
    int   m_held    = 0;

    bit   saw_to    = 1'b0;

    always #5 clk = ~clk;

    axi_lite_ic_arbiter #(
        .NUM_M   (N),
        .TIMEOUT (TO)
    ) dut (
        .aclk        (clk),
        .areset_n    (areset_n),
        .aw_req      (aw_req),
        .ar_req      (ar_req),
        .wr_done     (wr_done),
        .rd_done     (rd_done),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_write (grant_write),
        .busy        (busy),
        .timeout     (timeout)
    );

    task automatic check_cond(input bit ok, input string msg);
        n_checks++;
        if (!ok) begin
            $display("FAIL %s @%0t: grant=%b id=%0d wr=%b busy=%b to=%b",
                     msg, $time, grant, grant_id, grant_write, busy, timeout);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_step();
        exp_t e;
        bit   to_pulse = 1'b0;
        if (!areset_n) begin
            m_owner   = -1;
            m_write   = 1'b0;
            m_rr      = N - 1;
            m_pref_wr = 1'b1;
            m_held    = 0;
        end else if (m_owner < 0) begin
            for (int i = 1; i <= N; i++) begin
                int m;
                m = (m_rr + i) % N;
                if (aw_req[m] || ar_req[m]) begin
                    m_owner = m;
                    if (aw_req[m] && ar_req[m]) begin
                        m_write   = m_pref_wr;
                        m_pref_wr = !m_pref_wr;
                    end else begin
                        m_write = aw_req[m];
                    end
                    m_held = 1;
                    break;
                end
            end
        end else begin
            if (m_write ? wr_done : rd_done) begin
                m_rr    = m_owner;
                m_owner = -1;
            end else if (TO_EN && (m_held == TO)) begin
                m_rr     = m_owner;
                m_owner  = -1;
                to_pulse = 1'b1;
            end else begin
                m_held++;
            end
        end
        e       = '0;
        e.to    = to_pulse;
        if (m_owner >= 0) begin
            e.grant[m_owner] = 1'b1;
            e.id             = IDW'(m_owner);
            e.wr             = m_write;
            e.busy           = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{grant: grant, id: grant_id, wr: grant_write, busy: busy, to: timeout};
            n_checks++;
            if (got !== e) begin
                $display("FAIL outputs @%0t: got grant=%b id=%0d wr=%b busy=%b to=%b, expected grant=%b id=%0d wr=%b busy=%b to=%b",
                         $time, got.grant, got.id, got.wr, got.busy, got.to,
                         e.grant, e.id, e.wr, e.busy, e.to);
            end else begin
                n_pass++;
            end
        end
    end

    initial begin
        areset_n = 1'b0;
        aw_req   = 2'b11;
        ar_req   = '0;
        wr_done  = 1'b0;
        rd_done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cond((grant === '0) && (grant_id === '0) && (grant_write === 1'b0) &&
                   (busy === 1'b0) && (timeout === 1'b0), "reset state");
        #1 areset_n = 1'b1;

        // Fully random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            areset_n = ($urandom_range(0, 299) != 0);
            aw_req   = N'($urandom);
            ar_req   = N'($urandom);
            wr_done  = ($urandom_range(0, 2) == 0);
            rd_done  = ($urandom_range(0, 2) == 0);
        end

        // Both masters reading, no completions: watchdog expiry or indefinite hold.
        @(posedge clk);
        #2;
        areset_n = 1'b1;
        aw_req   = '0;
        ar_req   = 2'b11;
        wr_done  = 1'b0;
        rd_done  = 1'b0;
        saw_to   = 1'b0;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk);
            #1;
            if (timeout === 1'b1) begin
                saw_to = 1'b1;
            end
        end
        if (TO_EN) begin
            check_cond(saw_to, "expired wait: watchdog pulse");
        end else begin
            check_cond(!saw_to && (busy === 1'b1) && $onehot(grant), "expired wait: grant held");
        end

        // Reset in the middle of a held grant, then restart arbitration.
        #1 areset_n = 1'b0;
        @(posedge clk);
        #2;
        areset_n = 1'b1;
        aw_req   = 2'b11;
        ar_req   = 2'b01;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #2;
            wr_done = ($urandom_range(0, 3) == 0);
            rd_done = ($urandom_range(0, 3) == 0);
        end

        @(posedge clk);
        #2;
        aw_req  = '0;
        ar_req  = '0;
        wr_done = 1'b0;
        rd_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
